// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat deal sequencer.
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EVAL,
        S_P3,
        S_EVAL3,
        S_D3,
        S_DONE
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    localparam logic [3:0] FACE_RANK_MIN    = 4'd10;

    // Tens and face cards are worth nothing; other ranks count at face value.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= FACE_RANK_MIN) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/banker_draw.sv
// Banker third-card rule, decided from the banker score and the player's third card.
module banker_draw
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    assign v = card_value(pcard3);

    // Banker draws on low scores, or on mid scores depending on the player's third card.
    // Scores above 6 (including out-of-range values) always stand.
    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_sequencer.sv
// Moore sequencer that deals one baccarat hand and lights the outcome.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_RST   | idle after reset, nothing dealt
//   S_P1    | load player card 1
//   S_D1    | load dealer card 1
//   S_P2    | load player card 2
//   S_D2    | load dealer card 2
//   S_EVAL  | check naturals and player third-card rule
//   S_P3    | load player card 3
//   S_EVAL3 | apply banker rule against player card 3
//   S_D3    | load dealer card 3
//   S_DONE  | hand complete, outcome lights valid
module deal_sequencer
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore_out,
    input  logic [3:0] dscore_out,
    input  logic [3:0] pcard3_out,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t state_q;
    state_t state_d;
    logic   banker_draws;
    logic   natural;

    banker_draw u_banker_draw (
        .dscore (dscore_out),
        .pcard3 (pcard3_out),
        .draw   (banker_draws)
    );

    assign natural = (pscore_out >= NATURAL_MIN) || (dscore_out >= NATURAL_MIN);

    // Next-state selection; the deal is a fixed walk until the evaluation points.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_P1;
            S_P1:    state_d = S_D1;
            S_D1:    state_d = S_P2;
            S_P2:    state_d = S_D2;
            S_D2:    state_d = S_EVAL;
            S_EVAL: begin
                if (natural)
                    state_d = S_DONE;
                else if (pscore_out < PLAYER_STAND_MIN)
                    state_d = S_P3;
                else if (dscore_out < PLAYER_STAND_MIN)
                    state_d = S_D3;
                else
                    state_d = S_DONE;
            end
            S_P3:    state_d = S_EVAL3;
            S_EVAL3: state_d = banker_draws ? S_D3 : S_DONE;
            S_D3:    state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RST;
        endcase
    end

    // State register, the only storage in the block.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    assign load_pcard1 = (state_q == S_P1);
    assign load_dcard1 = (state_q == S_D1);
    assign load_pcard2 = (state_q == S_P2);
    assign load_dcard2 = (state_q == S_D2);
    assign load_pcard3 = (state_q == S_P3);
    assign load_dcard3 = (state_q == S_D3);

    // A tie lights both lamps, so each lamp is "not losing".
    assign player_win_light = (state_q == S_DONE) && (pscore_out >= dscore_out);
    assign dealer_win_light = (state_q == S_DONE) && (dscore_out >= pscore_out);

endmodule

// File: tb/tb_deal_sequencer.sv
// Self-checking bench for deal_sequencer: table-driven hands plus reset corner cases.
module tb_deal_sequencer;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] pscore_out;
    logic [3:0] dscore_out;
    logic [3:0] pcard3_out;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
    logic [7:0] dut_vec;

    int total = 0;
    int bad   = 0;

    deal_sequencer dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore_out       (pscore_out),
        .dscore_out       (dscore_out),
        .pcard3_out       (pcard3_out),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    // Order: p1 p2 p3 d1 d2 d3 pwin dwin
    assign dut_vec = {load_pcard1, load_pcard2, load_pcard3,
                      load_dcard1, load_dcard2, load_dcard3,
                      player_win_light, dealer_win_light};

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string      name;
        logic [3:0] p;
        logic [3:0] d;
        logic [3:0] c;
        logic [3:0] fp;
        logic [3:0] fd;
        logic       pdraw;
        logic       ddraw;
        int         done;
        logic       pw;
        logic       dw;
    } vec_t;

    localparam int NVEC   = 13;
    localparam int NEDGES = 11;

    vec_t       vecs [NVEC];
    logic [7:0] sb_q [$];

    function automatic vec_t mk(string name, logic [3:0] p, logic [3:0] d, logic [3:0] c,
                                logic [3:0] fp, logic [3:0] fd, logic pdraw, logic ddraw,
                                int done, logic pw, logic dw);
        vec_t v;
        v.name = name; v.p = p; v.d = d; v.c = c; v.fp = fp; v.fd = fd;
        v.pdraw = pdraw; v.ddraw = ddraw; v.done = done; v.pw = pw; v.dw = dw;
        return v;
    endfunction

    // Expected strobes/lights after edge k of a hand, from the table row.
    function automatic logic [7:0] expect_at(int k, vec_t v);
        logic [5:0] s;
        logic [1:0] l;
        s = 6'b000000;
        l = 2'b00;
        case (k)
            1: s = 6'b100000;
            2: s = 6'b000100;
            3: s = 6'b010000;
            4: s = 6'b000010;
            default: s = 6'b000000;
        endcase
        if (v.pdraw) begin
            if (k == 6) s = 6'b001000;
            if (k == 8 && v.ddraw) s = 6'b000001;
        end else if (v.ddraw && k == 6) begin
            s = 6'b000001;
        end
        if (k >= v.done) l = {v.pw, v.dw};
        return {s, l};
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%b exp=%b", name, act, exp);
        end
    endtask

    // Assert reset away from the clock edge, confirm quiet outputs, release on a falling edge.
    task automatic do_reset(string name);
        @(negedge slow_clock);
        resetb = 1'b0;
        #1;
        check({name, " reset"}, dut_vec, 8'h00);
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    initial begin
        resetb     = 1'b0;
        pscore_out = 4'd0;
        dscore_out = 4'd0;
        pcard3_out = 4'd0;

        //           name          p      d      c      fp     fd     pd    dd    done pw    dw
        vecs[0]  = mk("natural",    4'd8,  4'd3,  4'd0,  4'd8,  4'd3,  1'b0, 1'b0, 6, 1'b1, 1'b0);
        vecs[1]  = mk("both_draw",  4'd4,  4'd5,  4'd6,  4'd0,  4'd7,  1'b1, 1'b1, 9, 1'b0, 1'b1);
        vecs[2]  = mk("face_stand", 4'd4,  4'd4,  4'd13, 4'd4,  4'd4,  1'b1, 1'b0, 8, 1'b1, 1'b1);
        vecs[3]  = mk("b3_c8",      4'd4,  4'd3,  4'd8,  4'd4,  4'd3,  1'b1, 1'b0, 8, 1'b1, 1'b0);
        vecs[4]  = mk("b3_c9",      4'd4,  4'd3,  4'd9,  4'd4,  4'd3,  1'b1, 1'b1, 9, 1'b1, 1'b0);
        vecs[5]  = mk("p_stand",    4'd6,  4'd5,  4'd0,  4'd6,  4'd5,  1'b0, 1'b1, 7, 1'b1, 1'b0);
        vecs[6]  = mk("both_stand", 4'd7,  4'd6,  4'd0,  4'd7,  4'd6,  1'b0, 1'b0, 6, 1'b1, 1'b0);
        vecs[7]  = mk("d_natural",  4'd2,  4'd9,  4'd0,  4'd2,  4'd9,  1'b0, 1'b0, 6, 1'b0, 1'b1);
        vecs[8]  = mk("b2_always",  4'd5,  4'd2,  4'd8,  4'd5,  4'd2,  1'b1, 1'b1, 9, 1'b1, 1'b0);
        vecs[9]  = mk("b6_c7",      4'd3,  4'd6,  4'd7,  4'd3,  4'd6,  1'b1, 1'b1, 9, 1'b0, 1'b1);
        vecs[10] = mk("b6_c5",      4'd3,  4'd6,  4'd5,  4'd3,  4'd6,  1'b1, 1'b0, 8, 1'b0, 1'b1);
        vecs[11] = mk("b5_jack",    4'd1,  4'd5,  4'd11, 4'd1,  4'd5,  1'b1, 1'b0, 8, 1'b0, 1'b1);
        vecs[12] = mk("p_over9",    4'd12, 4'd3,  4'd0,  4'd12, 4'd3,  1'b0, 1'b0, 6, 1'b1, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            pscore_out = vecs[i].p;
            dscore_out = vecs[i].d;
            pcard3_out = vecs[i].c;
            do_reset(vecs[i].name);
            for (int k = 1; k <= NEDGES; k++) begin
                sb_q.push_back(expect_at(k, vecs[i]));
                @(posedge slow_clock);
                #1;
                // Once the hand is done the datapath would hold the final scores.
                if (k == vecs[i].done) begin
                    pscore_out = vecs[i].fp;
                    dscore_out = vecs[i].fd;
                end
                #1;
                check($sformatf("%s edge%0d", vecs[i].name, k), dut_vec, sb_q.pop_front());
            end
        end

        // Reset mid-deal: abort in S_D1 between edges, then restart cleanly.
        pscore_out = 4'd4;
        dscore_out = 4'd5;
        pcard3_out = 4'd6;
        do_reset("middeal");
        @(posedge slow_clock);
        #1;
        check("middeal p1", dut_vec, 8'b100000_00);
        @(posedge slow_clock);
        #1;
        check("middeal d1", dut_vec, 8'b000100_00);
        #2;
        resetb = 1'b0;
        #1;
        check("middeal async", dut_vec, 8'h00);
        @(posedge slow_clock);
        #1;
        check("middeal held", dut_vec, 8'h00);
        @(negedge slow_clock);
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        check("middeal restart p1", dut_vec, 8'b100000_00);
        @(posedge slow_clock);
        #1;
        check("middeal restart d1", dut_vec, 8'b000100_00);

        // Reset out of S_DONE clears the lights immediately.
        pscore_out = 4'd8;
        dscore_out = 4'd8;
        for (int k = 0; k < 5; k++) @(posedge slow_clock);
        #1;
        check("done tie", dut_vec, 8'b000000_11);
        #2;
        resetb = 1'b0;
        #1;
        check("done async reset", dut_vec, 8'h00);
        @(negedge slow_clock);
        resetb = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deal_sequencer.md
DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001 The block SHALL have these ports: slow_clock  in  1  sole clock; all state changes occur on its rising edge.
REQ-002 resetb  in  1  reset, asynchronous and active-low.
REQ-003 pscore_out  in  4  player hand score, 0..9, combinational from the loaded player cards.
REQ-004 dscore_out  in  4  dealer hand score, 0..9.
REQ-005 pcard3_out  in  4  raw rank of player card 3: 0 = empty, 1..13 = A..K.
REQ-006 load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle load strobes to the datapath.
REQ-007 player_win_light, dealer_win_light  out  1 each  outcome lights.

Function
REQ-010 The state machine SHALL be Moore-type, with states S_RST, S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_EVAL3, S_D3, S_DONE.
REQ-011 The unconditional sequence SHALL be S_RST->S_P1->S_D1->S_P2->S_D2->S_EVAL, one state per edge.
REQ-012 Each of S_P1, S_D1, S_P2, S_D2, S_P3, S_D3 SHALL assert exactly its own load strobe (pcard1, dcard1, pcard2, dcard2, pcard3, dcard3); every other state asserts no strobe.
REQ-013 The block SHALL never assert more than one strobe in any cycle.
REQ-014 S_EVAL transitions, evaluated in this priority order:
- pscore_out>=8 or dscore_out>=8 (natural): go to S_DONE.
- pscore_out<=5: go to S_P3.
- dscore_out<=5: go to S_D3.
- otherwise: go to S_DONE.
REQ-015 S_P3 SHALL always go to S_EVAL3.
REQ-016 In S_EVAL3, the third-card value v SHALL be 0 when pcard3_out>=10; otherwise v equals pcard3_out.
REQ-017 S_EVAL3 SHALL go to S_D3 when any of these holds; otherwise it goes to S_DONE:
- dscore_out<=2.
- dscore_out==3 and v!=8.
- dscore_out==4 and v in 2..7.
- dscore_out==5 and v in 4..7.
- dscore_out==6 and v in 6..7.
REQ-018 S_D3 SHALL always go to S_DONE.
REQ-019 S_DONE SHALL hold until reset.
REQ-020 The lights SHALL be 0 in every state except S_DONE.
REQ-021 In S_DONE, the lights SHALL be combinational from the scores:
- player_win_light = pscore_out>dscore_out.
- dealer_win_light = dscore_out>pscore_out.
- On a tie, both lights are 1.
REQ-022 Scores and pcard3_out SHALL be treated as unsigned 4-bit; an input value >9 is treated as >=8 in REQ-014 and REQ-017 (no special case).
REQ-023 Latency from reset release SHALL be, counted in slow_clock edges to reach S_DONE:
- Natural: 6.
- Player stands, dealer draws: 7.
- Player draws, dealer stands: 8.
- Both draw: 9.

Reset
REQ-030 When resetb=0, the state SHALL go to S_RST immediately, independent of slow_clock.
REQ-031 During reset, all strobes and both lights SHALL be 0.
REQ-032 Reset asserted in any state, including mid-deal, SHALL abort the hand with no further strobe.
REQ-033 After reset release, S_P1 SHALL be entered on the first rising edge of slow_clock.

Structure
REQ-040 Package baccarat_pkg SHALL hold:
- The state enum.
- Constants NATURAL_MIN=8, PLAYER_STAND_MIN=6, FACE_RANK_MIN=10.
REQ-041 The banker third-card table (REQ-016/REQ-017) SHALL be a combinational sub-module banker_draw (inputs dscore 4b and pcard3 rank 4b; output draw 1b), instantiated once.
REQ-042 The state register SHALL be the only sequential element; strobes and lights are decoded from the state.

Verification
REQ-050 The bench SHALL drive the score and card inputs directly, cover each scenario below, and flag any mismatch:
- Natural: pscore=8, dscore=3 at S_D2->S_EVAL -> S_DONE after 6 edges; player_win=1, dealer_win=0; load_pcard3 and load_dcard3 never asserted.
- Both draw: pscore=4, dscore=5, then pcard3_out=6 -> load_pcard3 then load_dcard3 pulses; with final p=0, d=7: dealer_win=1, player_win=0 at edge 9.
- Face-card banker stand: pscore=4, dscore=4, pcard3_out=13 (v=0) -> no load_dcard3; S_DONE at edge 8; tie, so both lights are 1.
- Banker-3 rule: dscore=3 with pcard3_out=8 -> no load_dcard3; repeat with pcard3_out=9 -> load_dcard3 asserted.
- Player stands: pscore=6, dscore=5 -> load_dcard3 at S_D3, no load_pcard3; repeat with pscore=7, dscore=6 -> S_DONE with no third cards, player_win=1.
- Reset mid-deal: resetb=0 while in S_D1 (between edges) -> all strobes 0 immediately; after release, load_pcard1 asserted after the first edge.
